load_use_hazard_ctrl: RTL and testbench
=======================================

# load_use_hazard_ctrl

Parametrised hazard-control unit for the 5-stage pipeline, sitting between ID and EX and driving the PC, IF/ID and ID/EX pipeline-register controls. It detects load-use dependencies between the instruction in ID and a load in EX, with per-operand use qualifiers and an optional x0 exemption. It holds the front end for a configurable number of cycles to cover a multi-cycle data-memory load latency. It also arbitrates taken-branch flushes against stalls and keeps a saturating stall-cycle performance counter.

## Interface
- REG_ADDR_W, 5, register-index width
- LOAD_LATENCY, 1, stall cycles per load-use hazard (≥1)
- ZERO_REG_EXEMPT, 1, when 1 a load with rd = 0 never causes a stall
- STALL_CNT_W, 16, width of the stall performance counter

Ports:
- clk  in  1  clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high
- id_rs1  in  REG_ADDR_W  source register 1 of the ID instruction
- id_rs2  in  REG_ADDR_W  source register 2 of the ID instruction
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- ex_rd  in  REG_ADDR_W  destination of the EX instruction
- ex_mem_read  in  1  EX instruction is a load
- ex_branch_taken  in  1  branch or jump resolved taken in EX
- stall  out  1  front-end hold this cycle
- pc_write_en  out  1  equals ~stall
- ifid_write_en  out  1  equals ~stall
- idex_bubble  out  1  insert a NOP into ID/EX this cycle
- ifid_flush  out  1  squash the IF/ID contents
- stall_cycles  out  STALL_CNT_W  saturating count of cycles with stall = 1

## Operation
- hazard = ex_mem_read & ~(ZERO_REG_EXEMPT & ex_rd == 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
- The FSM has two states, IDLE and HOLD, and a down-counter remain of width clog2(LOAD_LATENCY) + 1.
- IDLE:
  - stall = hazard & ~ex_branch_taken.
  - If stall and LOAD_LATENCY > 1: go to HOLD and load remain = LOAD_LATENCY − 1.
  - Otherwise stay in IDLE.
- HOLD:
  - stall = 1 unconditionally. EX holds a bubble, so hazard inputs are ignored.
  - remain decrements every cycle. When remain = 1 this cycle, go to IDLE.
  - If ex_branch_taken = 1: go to IDLE immediately, stall = 0, remain cleared.
- Flush:
  - ifid_flush = ex_branch_taken.
  - idex_bubble = stall | ex_branch_taken.
  - Flush always has priority over stall; the two never both cause a hold in the same cycle.
- stall_cycles increments by 1 in every cycle where stall = 1 and reset = 0.
  - It saturates at all-ones and never wraps.
- reset = 1 (including mid-HOLD):
  - Next state is IDLE, remain = 0, stall_cycles = 0.
  - In the reset cycle all outputs are forced: stall = 0, pc_write_en = 1, ifid_write_en = 1, idex_bubble = 0, ifid_flush = 0.

## Timing
- Detection is combinational, with zero latency. stall asserts in the same cycle the hazard is present in IDLE.
- A hazard detected in IDLE produces exactly LOAD_LATENCY consecutive stall cycles, unless a flush or reset intervenes.
- With LOAD_LATENCY = 1 the FSM never leaves IDLE. The pipeline itself removes the hazard on the next cycle, when the load has moved to MEM and a bubble is in EX.
- Back-to-back hazards: after HOLD returns to IDLE, a new hazard in that same cycle starts a new stall window with no gap.
- pc_write_en and ifid_write_en are the exact complement of stall in every cycle.
- Registered state (FSM, remain, stall_cycles) updates only on the rising edge of clk.

## Test plan
- Basic load-use, LOAD_LATENCY = 1:
  - Stimulus: ex_mem_read = 1, ex_rd = 5, id_rs1 = 5, id_uses_rs1 = 1.
  - Required: stall = 1, pc_write_en = 0, idex_bubble = 1 for exactly 1 cycle; stall_cycles = 1.
- x0 exemption and use qualifiers:
  - Stimulus: ex_rd = 0 = id_rs1 with ZERO_REG_EXEMPT = 1, giving stall = 0.
  - Stimulus: ex_rd = 7 = id_rs2 with id_uses_rs2 = 0, giving stall = 0.
  - Stimulus: the first case with ZERO_REG_EXEMPT = 0, giving stall = 1.
- Multi-cycle load, LOAD_LATENCY = 3:
  - Stimulus: a hazard on rs2 (rd = 12) for one cycle, then EX carries a bubble.
  - Required: stall = 1 for exactly 3 consecutive cycles, then 0; stall_cycles = 3.
- Flush priority, LOAD_LATENCY = 3:
  - Stimulus: a hazard and ex_branch_taken = 1 in the same cycle.
  - Required: stall = 0, ifid_flush = 1, idex_bubble = 1, and the FSM stays in IDLE.
  - Stimulus: ex_branch_taken = 1 in the 2nd HOLD cycle.
  - Required: stall = 0 from that cycle on.
- Reset mid-HOLD:
  - Stimulus: with LOAD_LATENCY = 4, assert reset in the 2nd stall cycle.
  - Required: outputs are inactive in the reset cycle; the next cycle is IDLE with stall = 0; stall_cycles = 0.
- Counter saturation:
  - Stimulus: STALL_CNT_W = 3 and 10 stall cycles.
  - Required: stall_cycles = 7 and it holds at 7.

Source files
------------

// File: rtl/load_use_hazard_ctrl_if.sv
// Signal bundle between the ID/EX pipeline boundary and the load-use hazard unit.
// Latency: none, plain wires; the hazard unit answers combinationally on the same bundle.
// Backpressure: stall/pc_write_en/ifid_write_en are the hold controls carried back to the front end.
interface load_use_hazard_ctrl_if #(
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 16
);
  logic [REG_ADDR_W-1:0]  id_rs1;
  logic [REG_ADDR_W-1:0]  id_rs2;
  logic                   id_uses_rs1;
  logic                   id_uses_rs2;
  logic [REG_ADDR_W-1:0]  ex_rd;
  logic                   ex_mem_read;
  logic                   ex_branch_taken;
  logic                   stall;
  logic                   pc_write_en;
  logic                   ifid_write_en;
  logic                   idex_bubble;
  logic                   ifid_flush;
  logic [STALL_CNT_W-1:0] stall_cycles;

  // Pipeline side: presents ID/EX operands, consumes the hold/flush controls.
  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read, ex_branch_taken,
    input  stall, pc_write_en, ifid_write_en, idex_bubble, ifid_flush, stall_cycles
  );

  // Hazard unit side.
  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read, ex_branch_taken,
    output stall, pc_write_en, ifid_write_en, idex_bubble, ifid_flush, stall_cycles
  );
endinterface

// File: rtl/load_use_hazard_ctrl.sv
// Load-use hazard detection, multi-cycle load hold, branch-flush arbitration, stall counter.
// Latency: combinational detect; a hazard seen in IDLE gives exactly LOAD_LATENCY stall cycles.
// Backpressure: stall holds PC and IF/ID and bubbles ID/EX; a taken branch overrides any stall.
module load_use_hazard_ctrl #(
  parameter int REG_ADDR_W      = 5,
  parameter int LOAD_LATENCY    = 1,
  parameter int ZERO_REG_EXEMPT = 1,
  parameter int STALL_CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  load_use_hazard_ctrl_if.slave hz
);
  localparam int REM_W = $clog2(LOAD_LATENCY) + 1;

  typedef enum logic {IDLE, HOLD} stateT;

  stateT                  state;
  stateT                  stateNext;
  logic [REM_W-1:0]       remain;
  logic [REM_W-1:0]       remainNext;
  logic                   hazard;
  logic                   rdExempt;
  logic                   stallInt;
  logic [STALL_CNT_W-1:0] stallCnt;

  // A load writing x0 produces nothing a consumer can depend on when the exemption is enabled.
  assign rdExempt = (ZERO_REG_EXEMPT != 0) && (hz.ex_rd == '0);

  // Load in EX whose destination matches a source the ID instruction actually reads.
  assign hazard = hz.ex_mem_read && !rdExempt &&
                  ((hz.id_uses_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                   (hz.id_uses_rs2 && (hz.id_rs2 == hz.ex_rd)));

  // Next-state and stall decision; a taken branch always wins over holding.
  always_comb begin
    stateNext  = state;
    remainNext = remain;
    stallInt   = 1'b0;
    if (reset) begin
      stateNext  = IDLE;
      remainNext = '0;
    end else begin
      case (state)
        IDLE: begin
          stallInt = hazard && !hz.ex_branch_taken;
          if (stallInt && (LOAD_LATENCY > 1)) begin
            stateNext  = HOLD;
            remainNext = REM_W'(LOAD_LATENCY - 1);
          end
        end
        HOLD: begin
          if (hz.ex_branch_taken) begin
            stateNext  = IDLE;
            remainNext = '0;
          end else begin
            // EX carries a bubble while holding, so the hazard inputs are not looked at.
            stallInt   = 1'b1;
            remainNext = remain - REM_W'(1);
            if (remain == REM_W'(1)) begin
              stateNext = IDLE;
            end
          end
        end
        default: begin
          stateNext  = IDLE;
          remainNext = '0;
        end
      endcase
    end
  end

  // FSM state and hold down-counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      remain <= '0;
    end else begin
      state  <= stateNext;
      remain <= remainNext;
    end
  end

  // Saturating count of stalled cycles; sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      stallCnt <= '0;
    end else if (stallInt && (stallCnt != '1)) begin
      stallCnt <= stallCnt + STALL_CNT_W'(1);
    end
  end

  // During reset every control is forced inactive, including the flush path.
  assign hz.stall         = stallInt;
  assign hz.pc_write_en   = !stallInt;
  assign hz.ifid_write_en = !stallInt;
  assign hz.idex_bubble   = !reset && (stallInt || hz.ex_branch_taken);
  assign hz.ifid_flush    = !reset && hz.ex_branch_taken;
  assign hz.stall_cycles  = stallCnt;
endmodule

// File: tb/tb_load_use_hazard_ctrl.sv
// Self-checking bench: three hazard units with different parameters share one stimulus stream.
// Latency: outputs are checked 1ns after the falling edge that applied the inputs.
// Backpressure: expected stalls come from a per-unit model counting remaining hold cycles.
module tb_load_use_hazard_ctrl;
  logic clk;
  logic reset;
  logic [4:0] rs1, rs2, rd;
  logic useRs1, useRs2, memRead, brTaken;

  int compareCnt = 0;
  int errCnt     = 0;

  // Per-unit parameters: u0 LL=1 exempt, u1 LL=3 exempt, u2 LL=4 no exemption with a 3-bit counter.
  int llV[3]  = '{1, 3, 4};
  int zreV[3] = '{1, 1, 0};
  int cwV[3]  = '{16, 16, 3};

  // Model state: stall cycles still owed by the current window, and the expected counter.
  int holdLeft[3];
  int cntM[3];

  load_use_hazard_ctrl_if #(.REG_ADDR_W(5), .STALL_CNT_W(16)) if0 ();
  load_use_hazard_ctrl_if #(.REG_ADDR_W(5), .STALL_CNT_W(16)) if1 ();
  load_use_hazard_ctrl_if #(.REG_ADDR_W(5), .STALL_CNT_W(3))  if2 ();

  load_use_hazard_ctrl #(.REG_ADDR_W(5), .LOAD_LATENCY(1), .ZERO_REG_EXEMPT(1), .STALL_CNT_W(16))
    u0 (.clk(clk), .reset(reset), .hz(if0));
  load_use_hazard_ctrl #(.REG_ADDR_W(5), .LOAD_LATENCY(3), .ZERO_REG_EXEMPT(1), .STALL_CNT_W(16))
    u1 (.clk(clk), .reset(reset), .hz(if1));
  load_use_hazard_ctrl #(.REG_ADDR_W(5), .LOAD_LATENCY(4), .ZERO_REG_EXEMPT(0), .STALL_CNT_W(3))
    u2 (.clk(clk), .reset(reset), .hz(if2));

  assign if0.id_rs1 = rs1;  assign if1.id_rs1 = rs1;  assign if2.id_rs1 = rs1;
  assign if0.id_rs2 = rs2;  assign if1.id_rs2 = rs2;  assign if2.id_rs2 = rs2;
  assign if0.id_uses_rs1 = useRs1;  assign if1.id_uses_rs1 = useRs1;  assign if2.id_uses_rs1 = useRs1;
  assign if0.id_uses_rs2 = useRs2;  assign if1.id_uses_rs2 = useRs2;  assign if2.id_uses_rs2 = useRs2;
  assign if0.ex_rd = rd;  assign if1.ex_rd = rd;  assign if2.ex_rd = rd;
  assign if0.ex_mem_read = memRead;  assign if1.ex_mem_read = memRead;  assign if2.ex_mem_read = memRead;
  assign if0.ex_branch_taken = brTaken;  assign if1.ex_branch_taken = brTaken;  assign if2.ex_branch_taken = brTaken;

  logic        oStall[3], oPc[3], oIfid[3], oBub[3], oFl[3];
  logic [15:0] oCnt[3];
  assign oStall[0] = if0.stall;  assign oStall[1] = if1.stall;  assign oStall[2] = if2.stall;
  assign oPc[0] = if0.pc_write_en;  assign oPc[1] = if1.pc_write_en;  assign oPc[2] = if2.pc_write_en;
  assign oIfid[0] = if0.ifid_write_en;  assign oIfid[1] = if1.ifid_write_en;  assign oIfid[2] = if2.ifid_write_en;
  assign oBub[0] = if0.idex_bubble;  assign oBub[1] = if1.idex_bubble;  assign oBub[2] = if2.idex_bubble;
  assign oFl[0] = if0.ifid_flush;  assign oFl[1] = if1.ifid_flush;  assign oFl[2] = if2.ifid_flush;
  assign oCnt[0] = if0.stall_cycles;  assign oCnt[1] = if1.stall_cycles;  assign oCnt[2] = 16'(if2.stall_cycles);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int u, input logic [15:0] obs, input logic [15:0] exp);
    compareCnt++;
    assert (obs === exp) else begin
      errCnt++;
      $error("FAIL %s u%0d observed=%0d expected=%0d", tag, u, obs, exp);
    end
  endtask

  // One clock: apply inputs, check every unit against the model, then advance the model.
  task automatic step(input logic rst, input logic mr, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic us1, input logic us2, input logic br);
    int nHold[3];
    int nCnt[3];
    @(negedge clk);
    reset = rst; memRead = mr; rd = d; rs1 = s1; rs2 = s2;
    useRs1 = us1; useRs2 = us2; brTaken = br;
    #1;
    for (int i = 0; i < 3; i++) begin
      bit haz, st, bub, fl;
      int maxCnt;
      maxCnt = (1 << cwV[i]) - 1;
      haz = mr && !(zreV[i] != 0 && d == 0) && ((us1 && s1 == d) || (us2 && s2 == d));
      if (rst) begin
        st = 0; bub = 0; fl = 0;
        nHold[i] = 0; nCnt[i] = 0;
      end else begin
        if (holdLeft[i] > 0) begin
          st = !br;
          nHold[i] = br ? 0 : holdLeft[i] - 1;
        end else begin
          st = haz && !br;
          nHold[i] = st ? llV[i] - 1 : 0;
        end
        fl  = br;
        bub = st || br;
        nCnt[i] = (st && cntM[i] < maxCnt) ? cntM[i] + 1 : cntM[i];
      end
      chk("stall", i, 16'(oStall[i]), 16'(st));
      chk("pc_write_en", i, 16'(oPc[i]), 16'(!st));
      chk("ifid_write_en", i, 16'(oIfid[i]), 16'(!st));
      chk("idex_bubble", i, 16'(oBub[i]), 16'(bub));
      chk("ifid_flush", i, 16'(oFl[i]), 16'(fl));
      chk("stall_cycles", i, oCnt[i], 16'(cntM[i]));
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      holdLeft[i] = nHold[i];
      cntM[i]     = nCnt[i];
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1; memRead = 0; rd = 0; rs1 = 0; rs2 = 0; useRs1 = 0; useRs2 = 0; brTaken = 0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 3; i++) begin holdLeft[i] = 0; cntM[i] = 0; end

    // Reset state.
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    idle(1);

    // Basic load-use on rs1 (rd=5), then EX carries bubbles.
    step(0, 1, 5'd5, 5'd5, 5'd0, 1, 0, 0);
    idle(4);
    chk("basic_cnt_ll1", 0, oCnt[0], 16'd1);

    // rd=x0: exempt units ignore it, the non-exempt unit stalls.
    step(0, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0);
    idle(4);

    // Matching rs2 that the instruction does not read: no stall anywhere.
    step(0, 1, 5'd7, 5'd1, 5'd7, 1, 0, 0);
    idle(1);

    // Multi-cycle load on rs2 (rd=12).
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    step(0, 1, 5'd12, 5'd3, 5'd12, 0, 1, 0);
    idle(4);
    chk("multi_cnt_ll3", 1, oCnt[1], 16'd3);

    // Hazard and taken branch in the same cycle: flush wins, no hold.
    step(0, 1, 5'd9, 5'd9, 5'd9, 1, 1, 1);
    idle(2);

    // Taken branch arriving in the 2nd hold cycle ends the window.
    step(0, 1, 5'd4, 5'd4, 5'd0, 1, 0, 0);
    step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
    idle(3);

    // Reset during the 2nd stall cycle.
    step(0, 1, 5'd6, 5'd6, 5'd0, 1, 0, 0);
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    idle(2);

    // Back-to-back windows: 10 stall cycles saturate the 3-bit counter.
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    for (int k = 0; k < 10; k++) step(0, 1, 5'd2, 5'd2, 5'd2, 1, 1, 0);
    idle(2);
    chk("sat_cnt", 2, oCnt[2], 16'd7);
    step(0, 1, 5'd2, 5'd2, 5'd0, 1, 0, 0);
    idle(1);
    chk("sat_hold", 2, oCnt[2], 16'd7);

    // Randomized traffic with small register indices to make hazards frequent.
    for (int k = 0; k < 800; k++) begin
      step(($urandom_range(0, 49) == 0),
           ($urandom_range(0, 1) == 1),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 7) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCnt, errCnt);
    $finish;
  end
endmodule
